// File: rtl/life_pkg.sv
// Shared definitions for the game-of-life display path.
//   GRID_W       : width of one generation (8x8 cells, row 0 in the MSBs)
//   GEN_W        : width of the generation counter
//   grid_t       : one full generation
//   scan_state_t : row-scanner states (IDLE, BLANK, DRIVE)
package life_pkg;

  localparam int GRID_W = 64;
  localparam int GEN_W  = 16;

  typedef logic [GRID_W-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/life_row_mux.sv
// Row slice selector: picks the COLS-bit column pattern of one row out of a
// full generation. Row 0 occupies the top COLS bits of the grid; bit COLS-1
// of the slice is the leftmost cell.
//   grid     in  GRID_W   generation being displayed
//   row      in  RW       row index, 0..ROWS-1
//   col_data out COLS     cells of the selected row
module life_row_mux
  import life_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic [GRID_W-1:0] grid,
  input  logic [RW-1:0]     row,
  output logic [COLS-1:0]   col_data
);

  // Constant slices per row keep the select a plain mux tree.
  always_comb begin
    col_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == RW'(r)) begin
        col_data = grid[GRID_W-1-COLS*r -: COLS];
      end
    end
  end

endmodule

// File: rtl/life_grid_scanner.sv
// Double-buffered 8x8 LED matrix scanner for the game-of-life core.
// A generation handed over by the core lands in a shadow buffer and is
// swapped into the active (displayed) buffer only at a frame boundary, so a
// frame never mixes two generations. Each row is driven for DWELL clocks,
// preceded by one blank clock to suppress ghosting between rows.
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous reset, active-low
//   grid_in     in   GRID_W  generation from the core (row 0 = MSBs)
//   grid_valid  in   1       grid_in holds a new generation
//   grid_ready  out  1       shadow buffer empty; transfer on valid & ready
//   row_sel     out  ROWS    one-hot row drive, active-high
//   col_data    out  COLS    column data of the driven row, bit 7 = leftmost
//   frame_done  out  1       one-cycle pulse at the end of the last row
//   gen_count   out  GEN_W   generations swapped in, saturating
//   stable      out  1       last swapped-in generation equals its predecessor
module life_grid_scanner
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid_in,
  input  logic              grid_valid,
  output logic              grid_ready,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_data,
  output logic              frame_done,
  output logic [GEN_W-1:0]  gen_count,
  output logic              stable
);

  localparam int RW   = $clog2(ROWS);
  localparam int DW_W = $clog2(DWELL);

  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  scan_state_t     state;
  logic [RW-1:0]   row;
  logic [DW_W-1:0] dwell_cnt;
  grid_t           active_buf;
  grid_t           shadow_buf;
  logic            shadow_empty;
  logic [COLS-1:0] row_slice;

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (v == '1) ? v : v + GEN_W'(1);
  endfunction

  // Slice of the row that the next DRIVE state will show. row and
  // active_buf are already settled while in BLANK, so the registered
  // col_data picks up the correct pattern on the edge entering DRIVE.
  life_row_mux #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_row_mux (
    .grid     (active_buf),
    .row      (row),
    .col_data (row_slice)
  );

  // Outside IDLE the core may only hand over a generation when the shadow
  // buffer is free. In IDLE the shadow is always empty, so ready stays high
  // and the first generation goes straight into the active buffer.
  assign grid_ready = shadow_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      row          <= '0;
      dwell_cnt    <= '0;
      active_buf   <= '0;
      shadow_buf   <= '0;
      shadow_empty <= 1'b1;
      row_sel      <= '0;
      col_data     <= '0;
      frame_done   <= 1'b0;
      gen_count    <= '0;
      stable       <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Shadow fill while scanning. A swap below only happens with the
      // shadow full, so it never collides with this load; a valid arriving
      // in the swap cycle sees ready low and is held off one cycle.
      if (state != IDLE && grid_valid && shadow_empty) begin
        shadow_buf   <= grid_in;
        shadow_empty <= 1'b0;
      end

      case (state)
        IDLE: begin
          row_sel  <= '0;
          col_data <= '0;
          if (grid_valid) begin
            active_buf <= grid_in;
            gen_count  <= GEN_W'(1);
            row        <= '0;
            state      <= BLANK;
          end
        end

        BLANK: begin
          row_sel   <= ROWS'(1) << row;
          col_data  <= row_slice;
          dwell_cnt <= '0;
          state     <= DRIVE;
        end

        DRIVE: begin
          if (dwell_cnt == DWELL_LAST) begin
            row_sel  <= '0;
            col_data <= '0;
            state    <= BLANK;
            if (row == ROW_LAST) begin
              row        <= '0;
              frame_done <= 1'b1;
              // Frame boundary: promote a waiting generation. With no new
              // generation the current one is simply rescanned.
              if (!shadow_empty) begin
                active_buf   <= shadow_buf;
                shadow_empty <= 1'b1;
                gen_count    <= sat_inc(gen_count);
                stable       <= (shadow_buf == active_buf);
              end
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end
        end

        default: begin
          row_sel  <= '0;
          col_data <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
